// File: rtl/led_pkg.sv
// Shared types and constants for the LED scan sequencer: pattern modes, FSM
// states, scan direction and the per-step select update.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_PING    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [2:0] SEL_MAX = 3'd7;

  typedef struct packed {
    logic [2:0] sel;
    dir_t       dir;
  } scan_pos_t;

  // Next select code and direction for one step in the given pattern.
  // One-shot completion at SEL_MAX is handled by the FSM, not here.
  function automatic scan_pos_t next_pos(mode_t mode, logic [2:0] sel, dir_t dir);
    scan_pos_t r;
    // NOTE: r gets a full default first so every branch below leaves it
    // defined; the same habit keeps always_comb blocks latch-free.
    r.sel = sel;
    r.dir = dir;
    case (mode)
      MODE_UP, MODE_ONESHOT: r.sel = sel + 3'd1;
      MODE_DOWN:             r.sel = sel - 3'd1;
      MODE_PING: begin
        if (dir == DIR_UP) begin
          if (sel == SEL_MAX) begin
            r.sel = sel - 3'd1;
            r.dir = DIR_DOWN;
          end else begin
            r.sel = sel + 3'd1;
          end
        end else begin
          if (sel == 3'd0) begin
            r.sel = sel + 3'd1;
            r.dir = DIR_UP;
          end else begin
            r.sel = sel - 3'd1;
          end
        end
      end
      default: r.sel = sel;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Control/status bundle of the LED scan sequencer; master drives the
// run controls, slave (the sequencer) drives the decoder and status lines.
interface led_scan_ctrl_if;
  import led_pkg::*;

  logic       start;
  logic       stop;
  logic       hold;
  mode_t      mode;
  logic [2:0] sel;
  logic       dec_en;
  logic       busy;
  logic       step;
  logic       done;

  modport master (
    output start, stop, hold, mode,
    input  sel, dec_en, busy, step, done
  );

  modport slave (
    input  start, stop, hold, mode,
    output sel, dec_en, busy, step, done
  );

endinterface

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: counts 0..DIV-1 and flags the terminal count, with a
// synchronous clear and a hold that freezes the count.
module led_tick_gen #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking = here would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // A held cycle is not a step, even if the count sits at LAST.
  assign tick = (cnt == LAST) && !hold;

endmodule

// File: rtl/led_scan_ctrl.sv
// LED scan sequencer driving a 3-to-8 decoder: one LED lit at a time, stepped
// every DIV cycles in up, down, ping-pong or one-shot order.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int DIV = 25_000_000
) (
  input  logic           clk,
  input  logic           rst,
  led_scan_ctrl_if.slave bus
);

  state_t     state;
  mode_t      mode_q;
  dir_t       dir_q;
  logic [2:0] sel_q;
  logic       dec_en_q;
  logic       busy_q;
  logic       step_q;
  logic       done_q;

  logic       tick;
  logic       clr;
  scan_pos_t  nxt;

  // The prescaler idles at zero, which also makes the start edge clear it.
  assign clr = (state == IDLE) || bus.stop;

  led_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .hold (bus.hold),
    .tick (tick)
  );

  assign nxt = next_pos(mode_q, sel_q, dir_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= MODE_UP;
      dir_q    <= DIR_UP;
      sel_q    <= '0;
      dec_en_q <= 1'b0;
      busy_q   <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state    <= RUN;
            mode_q   <= bus.mode;
            sel_q    <= (bus.mode == MODE_DOWN) ? SEL_MAX : 3'd0;
            dir_q    <= (bus.mode == MODE_DOWN) ? DIR_DOWN : DIR_UP;
            dec_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state    <= IDLE;
            mode_q   <= MODE_UP;
            dir_q    <= DIR_UP;
            sel_q    <= '0;
            dec_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (tick) begin
            if (mode_q == MODE_ONESHOT && sel_q == SEL_MAX) begin
              state    <= IDLE;
              mode_q   <= MODE_UP;
              dir_q    <= DIR_UP;
              sel_q    <= '0;
              dec_en_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              sel_q  <= nxt.sel;
              dir_q  <= nxt.dir;
              step_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel    = sel_q;
  assign bus.dec_en = dec_en_q;
  assign bus.busy   = busy_q;
  assign bus.step   = step_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl at DIV=4: reset, all four patterns, hold,
// stop-on-tick, start+stop in IDLE and mid-run reset.
module tb_led_scan_ctrl;
  import led_pkg::*;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  led_scan_ctrl_if bus ();

  led_scan_ctrl #(.DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " sel"},    int'(bus.sel),    0);
    chk({tag, " dec_en"}, int'(bus.dec_en), 0);
    chk({tag, " busy"},   int'(bus.busy),   0);
    chk({tag, " step"},   int'(bus.step),   0);
    chk({tag, " done"},   int'(bus.done),   0);
  endtask

  int pp [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int steps;

  initial begin
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    bus.hold  = 1'b0;
    bus.mode  = MODE_UP;

    // Reset held with start asserted
    cyc(3);
    chk_idle("reset");
    rst = 1'b0;
    cyc(1);
    chk("post-reset busy", int'(bus.busy), 1);
    chk("post-reset sel", int'(bus.sel), 0);
    chk("post-reset dec_en", int'(bus.dec_en), 1);
    bus.start = 1'b0;
    bus.mode  = MODE_DOWN;  // must be ignored while running

    // Up pattern: sel after edge k+i is (i/4) mod 8
    steps = 0;
    for (int i = 1; i <= 32; i++) begin
      cyc(1);
      chk($sformatf("up sel i=%0d", i), int'(bus.sel), (i / 4) % 8);
      chk($sformatf("up step i=%0d", i), int'(bus.step), (i % 4 == 0) ? 1 : 0);
      chk($sformatf("up dec_en i=%0d", i), int'(bus.dec_en), 1);
      if (bus.step) steps++;
    end
    chk("up step count", steps, 8);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk_idle("up stop");

    // Ping-pong
    bus.mode  = MODE_PING;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk("ping start sel", int'(bus.sel), 0);
    for (int i = 1; i <= 60; i++) begin
      cyc(1);
      chk($sformatf("ping sel i=%0d", i), int'(bus.sel), pp[i / 4]);
    end
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk_idle("ping stop");

    // One-shot
    bus.mode  = MODE_ONESHOT;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      cyc(1);
      chk($sformatf("oneshot sel i=%0d", i), int'(bus.sel), i / 4);
      chk($sformatf("oneshot done i=%0d", i), int'(bus.done), 0);
      chk($sformatf("oneshot busy i=%0d", i), int'(bus.busy), 1);
    end
    cyc(1);
    chk("oneshot done at 32", int'(bus.done), 1);
    chk("oneshot dec_en at 32", int'(bus.dec_en), 0);
    chk("oneshot sel at 32", int'(bus.sel), 0);
    chk("oneshot busy at 32", int'(bus.busy), 0);
    chk("oneshot step at 32", int'(bus.step), 0);
    cyc(1);
    chk_idle("oneshot after done");
    cyc(3);
    chk_idle("oneshot stays idle");
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk("oneshot restart busy", int'(bus.busy), 1);
    chk("oneshot restart sel", int'(bus.sel), 0);
    cyc(4);
    chk("oneshot restart first step sel", int'(bus.sel), 1);
    chk("oneshot restart first step", int'(bus.step), 1);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk_idle("oneshot stop");

    // Down with a 6-cycle hold at sel=5
    bus.mode  = MODE_DOWN;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk("down start sel", int'(bus.sel), 7);
    cyc(4);
    chk("down first step sel", int'(bus.sel), 6);
    cyc(5);                 // after edge k+9
    chk("down sel before hold", int'(bus.sel), 5);
    bus.hold = 1'b1;
    cyc(6);                 // edges k+10..k+15 held
    chk("down sel during hold", int'(bus.sel), 5);
    chk("down dec_en during hold", int'(bus.dec_en), 1);
    bus.hold = 1'b0;
    cyc(2);                 // after edge k+17
    chk("down sel hold+2", int'(bus.sel), 5);
    chk("down step hold+2", int'(bus.step), 0);
    cyc(1);                 // after edge k+18
    chk("down sel delayed step", int'(bus.sel), 4);
    chk("down step delayed", int'(bus.step), 1);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk_idle("down stop");

    // Stop coincident with the tick at sel=3
    bus.mode  = MODE_UP;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(15);
    chk("stop-tick sel before", int'(bus.sel), 3);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk_idle("stop-tick");
    cyc(1);
    chk_idle("stop-tick next");

    // start and stop together in IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc(1);
    chk_idle("start+stop idle");
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    cyc(1);
    chk_idle("start+stop idle after");

    // Reset mid-run
    bus.mode  = MODE_PING;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(10);
    chk("mid-run sel", int'(bus.sel), 2);
    rst = 1'b1;
    cyc(1);
    chk_idle("mid-run reset");
    rst = 1'b0;
    cyc(2);
    chk_idle("after mid-run reset");

    // A fresh down start after reset still loads 7
    bus.mode  = MODE_DOWN;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(4);
    chk("down after reset sel", int'(bus.sel), 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
